// File: rtl/branch_resolver.sv
// branch_resolver: requests predictions for fetched branches, queues them in order,
// and resolves them against execute outcomes with mispredict flush and statistics.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    br_valid,
    output logic                    br_ready,
    output logic                    pred_request,
    input  logic                    pred_in,
    output logic                    pred_valid,
    output logic                    pred_taken,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    output logic                    upd_result,
    output logic                    upd_taken,
    output logic                    mispredict,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [CNT_W-1:0]        total_cnt,
    output logic [CNT_W-1:0]        miss_cnt,
    output logic                    err_underflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t          r_state, w_next;
    logic [DEPTH-1:0] r_q;
    logic [AW-1:0]   r_head, r_tail;
    logic [AW:0]     r_occ;
    logic [CNT_W-1:0] r_total, r_miss;
    logic            r_err;
    logic            w_ready, w_resolve, w_mis, w_push;

    // Combinational outputs are gated by rst_n so they read 0 while reset is held.
    always_comb begin
        w_ready   = rst_n && (r_state == IDLE) && (r_occ < (AW+1)'(DEPTH));
        w_resolve = rst_n && resolve_valid && (r_occ != '0);
        w_mis     = w_resolve && (r_q[r_head] != resolve_taken);
        w_push    = (r_state == CAPTURE) && !w_mis;
        w_next    = (r_state == IDLE && br_valid && w_ready) ? CAPTURE : IDLE;
    end

    assign br_ready      = w_ready;
    assign pred_request  = br_valid && w_ready;
    assign pred_valid    = w_push;
    assign pred_taken    = w_push && pred_in;
    assign upd_result    = w_resolve;
    assign upd_taken     = w_resolve && resolve_taken;
    assign mispredict    = w_mis;
    assign occupancy     = r_occ;
    assign total_cnt     = r_total;
    assign miss_cnt      = r_miss;
    assign err_underflow = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_total <= '0;
            r_miss  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (resolve_valid && r_occ == '0)
                r_err <= 1'b1;
            if (w_resolve && r_total != '1)
                r_total <= r_total + 1'b1;
            if (w_mis && r_miss != '1)
                r_miss <= r_miss + 1'b1;
            // A mispredict drops every younger entry and any capture in progress.
            if (w_mis) begin
                r_head <= r_tail;
                r_occ  <= '0;
            end else begin
                if (w_resolve)
                    r_head <= r_head + 1'b1;
                if (w_push) begin
                    r_q[r_tail] <= pred_in;
                    r_tail      <= r_tail + 1'b1;
                end
                r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_resolve);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: randomized and directed checks of branch_resolver against a
// queue-based reference model; a CNT_W=3 copy exercises counter saturation.
module tb_branch_resolver;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic br_valid = 1'b0, pred_in = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
    logic br_ready, pred_request, pred_valid, pred_taken, upd_result, upd_taken, mispredict, err_underflow;
    logic [2:0] occupancy;
    logic [CNT_W-1:0] total_cnt, miss_cnt;
    logic br_ready3, pred_request3, pred_valid3, pred_taken3, upd_result3, upd_taken3, mispredict3, err_underflow3;
    logic [2:0] occupancy3;
    logic [2:0] total3, miss3;

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .pred_request(pred_request), .pred_in(pred_in), .pred_valid(pred_valid),
        .pred_taken(pred_taken), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_result(upd_result), .upd_taken(upd_taken), .mispredict(mispredict),
        .occupancy(occupancy), .total_cnt(total_cnt), .miss_cnt(miss_cnt),
        .err_underflow(err_underflow)
    );

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready3),
        .pred_request(pred_request3), .pred_in(pred_in), .pred_valid(pred_valid3),
        .pred_taken(pred_taken3), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_result(upd_result3), .upd_taken(upd_taken3), .mispredict(mispredict3),
        .occupancy(occupancy3), .total_cnt(total3), .miss_cnt(miss3),
        .err_underflow(err_underflow3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: an ordered list of outstanding predictions plus plain counts.
    bit m_q[$];
    bit m_cap, m_err;
    int m_total, m_miss;
    bit e_ready, e_req, e_res, e_mis, e_pv;
    logic [6:0] e_comb;
    logic [40:0] e_st;

    wire [6:0]  comb = {br_ready, pred_request, pred_valid, pred_taken, upd_result, upd_taken, mispredict};
    wire [40:0] st   = {occupancy, total_cnt, miss_cnt, err_underflow, total3, miss3};

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    task automatic model_state();
        e_st = {3'(m_q.size()), 16'(sat(m_total, 65535)), 16'(sat(m_miss, 65535)), m_err,
                3'(sat(m_total, 7)), 3'(sat(m_miss, 7))};
    endtask

    task automatic m_reset();
        m_q.delete();
        m_cap = 0; m_err = 0; m_total = 0; m_miss = 0;
        model_state();
    endtask

    task automatic drive(input bit bv, input bit pin, input bit rv, input bit rt);
        @(negedge clk);
        br_valid = bv; pred_in = pin; resolve_valid = rv; resolve_taken = rt;
        #1;
        e_ready = !m_cap && m_q.size() < DEPTH;
        e_req   = bv && e_ready;
        e_res   = rv && m_q.size() > 0;
        e_mis   = e_res && (m_q[0] != rt);
        e_pv    = m_cap && !e_mis;
        e_comb  = {e_ready, e_req, e_pv, e_pv && pin, e_res, e_res && rt, e_mis};
    endtask

    task automatic tick();
        @(posedge clk);
        if (resolve_valid && m_q.size() == 0) m_err = 1;
        if (e_res) begin
            m_total++;
            if (e_mis) m_miss++;
            void'(m_q.pop_front());
        end
        if (e_mis) m_q.delete();
        else if (e_pv) m_q.push_back(pred_in);
        m_cap = e_req;
        #1;
        model_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; br_valid = 0; pred_in = 0; resolve_valid = 0; resolve_taken = 0;
        @(negedge clk);
        rst_n = 1;
        m_reset();
    endtask

    task automatic test_reset();
        br_valid = 1; pred_in = 1; resolve_valid = 1; resolve_taken = 1;
        @(posedge clk); #1;
        n_checks++; if ({comb, st} !== '0) begin n_err++; $display("FAIL reset outputs: got %h exp 0", {comb, st}); end
        do_reset();
        #1;
        n_checks++; if (st !== e_st) begin n_err++; $display("FAIL reset state: got %h exp %h", st, e_st); end
    endtask

    task automatic test_first_branch();
        do_reset();
        drive(1, 0, 0, 0);
        n_checks++; if (comb !== e_comb || pred_request !== 1'b1) begin n_err++; $display("FAIL first c0: got %b exp %b", comb, e_comb); end
        tick();
        drive(0, 1, 0, 0);
        n_checks++; if (comb !== e_comb || {pred_valid, pred_taken} !== 2'b11) begin n_err++; $display("FAIL first c1: got %b exp %b", comb, e_comb); end
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (occupancy !== 3'd1 || br_ready !== 1'b1 || st !== e_st) begin n_err++; $display("FAIL first c2: got %h exp %h", st, e_st); end
        tick();
    endtask

    task automatic test_fill();
        bit p[4];
        do_reset();
        for (int r = 0; r < 2; r++) begin
            p = '{1, 0, 1, 1};
            if (r == 1) for (int i = 0; i < 4; i++) p[i] = 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                drive(1, 0, 0, 0);
                n_checks++; if (comb !== e_comb) begin n_err++; $display("FAIL fill req %0d: got %b exp %b", i, comb, e_comb); end
                tick();
                drive(0, p[i], 0, 0);
                n_checks++; if (comb !== e_comb) begin n_err++; $display("FAIL fill cap %0d: got %b exp %b", i, comb, e_comb); end
                tick();
            end
            drive(1, 0, 0, 0);
            n_checks++; if (br_ready !== 1'b0 || pred_request !== 1'b0 || occupancy !== 3'd4) begin n_err++; $display("FAIL fill full: got ready=%b occ=%0d exp ready=0 occ=4", br_ready, occupancy); end
            tick();
            for (int i = 0; i < 4; i++) begin
                drive(0, 0, 1, p[i]);
                n_checks++; if (comb !== e_comb || {upd_result, upd_taken, mispredict} !== {1'b1, p[i], 1'b0}) begin n_err++; $display("FAIL fill resolve %0d: got %b exp %b", i, comb, e_comb); end
                tick();
            end
            n_checks++; if (total_cnt !== 16'(4 * (r + 1)) || miss_cnt !== 16'd0 || st !== e_st) begin n_err++; $display("FAIL fill counts: got %h exp %h", st, e_st); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0); tick();
            drive(0, 1, 0, 0); tick();
        end
        drive(1, 0, 0, 0);
        n_checks++; if (comb !== e_comb) begin n_err++; $display("FAIL flush req: got %b exp %b", comb, e_comb); end
        tick();
        drive(0, 1, 1, 0);
        n_checks++; if ({pred_valid, upd_result, upd_taken, mispredict} !== 4'b0101 || comb !== e_comb) begin n_err++; $display("FAIL flush resolve: got %b exp %b", comb, e_comb); end
        tick();
        n_checks++; if (occupancy !== 3'd0 || miss_cnt !== 16'd1 || st !== e_st) begin n_err++; $display("FAIL flush state: got %h exp %h", st, e_st); end
        drive(0, 1, 0, 0);
        n_checks++; if (pred_valid !== 1'b0 || comb !== e_comb) begin n_err++; $display("FAIL flush after: got %b exp %b", comb, e_comb); end
        tick();
    endtask

    task automatic test_simultaneous();
        bit a, b, c;
        a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
        do_reset();
        drive(1, 0, 0, 0); tick(); drive(0, a, 0, 0); tick();
        drive(1, 0, 0, 0); tick(); drive(0, b, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        drive(0, c, 1, a);
        n_checks++; if ({pred_valid, upd_result, mispredict} !== 3'b110 || comb !== e_comb) begin n_err++; $display("FAIL simul push+pop: got %b exp %b", comb, e_comb); end
        tick();
        n_checks++; if (occupancy !== 3'd2 || st !== e_st) begin n_err++; $display("FAIL simul occ: got %h exp %h", st, e_st); end
        drive(1, 0, 1, !b);
        n_checks++; if (mispredict !== 1'b1 || br_ready !== 1'b1 || comb !== e_comb) begin n_err++; $display("FAIL simul head: got %b exp %b", comb, e_comb); end
        tick();
        drive(0, 1, 0, 0);
        n_checks++; if (pred_valid !== 1'b1 || comb !== e_comb) begin n_err++; $display("FAIL simul refill: got %b exp %b", comb, e_comb); end
        tick();
        n_checks++; if (occupancy !== 3'd1 || st !== e_st) begin n_err++; $display("FAIL simul end: got %h exp %h", st, e_st); end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 0, 1, 1);
        n_checks++; if (upd_result !== 1'b0 || comb !== e_comb) begin n_err++; $display("FAIL underflow pulse: got %b exp %b", comb, e_comb); end
        tick();
        n_checks++; if (err_underflow !== 1'b1 || total_cnt !== 16'd0 || st !== e_st) begin n_err++; $display("FAIL underflow state: got %h exp %h", st, e_st); end
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 1, 0);
        n_checks++; if ({pred_valid, upd_result} !== 2'b10 || comb !== e_comb) begin n_err++; $display("FAIL underflow push: got %b exp %b", comb, e_comb); end
        tick();
        drive(0, 0, 0, 0); tick();
        n_checks++; if (err_underflow !== 1'b1 || occupancy !== 3'd1 || st !== e_st) begin n_err++; $display("FAIL underflow sticky: got %h exp %h", st, e_st); end
    endtask

    task automatic test_random();
        bit rv, rt;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 2) == 0);
            rt = (m_q.size() > 0 && $urandom_range(0, 3) != 0) ? m_q[0] : 1'($urandom);
            drive(1'($urandom), 1'($urandom), rv, rt);
            n_checks++; if (comb !== e_comb) begin n_err++; $display("FAIL random comb %0d: got %b exp %b", i, comb, e_comb); end
            tick();
            n_checks++; if (st !== e_st) begin n_err++; $display("FAIL random state %0d: got %h exp %h", i, st, e_st); end
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        @(negedge clk);
        br_valid = 1; pred_in = 1; resolve_valid = 1; resolve_taken = 1;
        #2 rst_n = 0;
        #1;
        n_checks++; if ({comb, st} !== '0) begin n_err++; $display("FAIL async reset: got %h exp 0", {comb, st}); end
        br_valid = 0; pred_in = 0; resolve_valid = 0; resolve_taken = 0;
        @(negedge clk);
        rst_n = 1;
        m_reset();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0); tick();
            drive(0, 1, 0, 0); tick();
            drive(0, 0, 1, 0);
            n_checks++; if (mispredict !== 1'b1 || comb !== e_comb) begin n_err++; $display("FAIL sat miss %0d: got %b exp %b", i, comb, e_comb); end
            tick();
            n_checks++; if (st !== e_st) begin n_err++; $display("FAIL sat state %0d: got %h exp %h", i, st, e_st); end
        end
        n_checks++; if ({total3, miss3} !== 6'o77 || {total_cnt, miss_cnt} !== {16'd9, 16'd9}) begin n_err++; $display("FAIL sat final: got %0d/%0d %0d/%0d exp 7/7 9/9", total3, miss3, total_cnt, miss_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_branch();
        test_fill();
        test_flush();
        test_simultaneous();
        test_underflow();
        test_random();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
